paralelo_serial: RTL and testbench
==================================

PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter COM SHALL default to 8'hBC; it is the comma/idle symbol.
REQ-003 Parameter SYNC_COUNT SHALL default to 4; it is the number of COM symbols sent after reset before data is accepted.
REQ-004 Port clk_32f SHALL be an input, 1 bit wide: the bit clock; one serial bit is sent per rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-006 Port data_in SHALL be an input, 8 bits wide: the parallel byte to send.
REQ-007 Port valid_in SHALL be an input, 1 bit wide: data_in is valid this cycle.
REQ-008 Port ready_out SHALL be an output, 1 bit wide: the block can accept data_in this cycle.
REQ-009 Port data_out SHALL be an output, 1 bit wide: the serial bit stream, MSB first.
REQ-010 Port active SHALL be an output, 1 bit wide: high once the sync preamble is done.

Function
REQ-011 The block SHALL hold an 8-bit shift register, a 3-bit bit counter, a 1-byte holding register with a full flag, a sync counter, and a two-state FSM (SYNC, ACTIVE).
REQ-012 data_out SHALL equal bit 7 of the shift register, so it is registered output.
REQ-013 On every clk_32f edge the bit counter SHALL increment, wrapping 7->0; an edge where the counter goes 7->0 is a byte boundary.
REQ-014 At a byte boundary the shift register SHALL load a byte; on all other edges it SHALL shift left by one and fill 0.
REQ-015 Byte load source: in SYNC, always COM; in ACTIVE, the holding register if full (which clears full), otherwise COM (idle fill).
REQ-016 SYNC: the sync counter SHALL increment on each COM load; at the boundary that loads the SYNC_COUNT-th COM, the FSM SHALL go to ACTIVE.
REQ-017 ACTIVE SHALL be left only through reset.
REQ-018 active SHALL equal (state == ACTIVE).
REQ-019 ready_out SHALL equal (state == ACTIVE) && (!full || byte boundary this edge).
REQ-020 A transfer occurs on a clock edge where valid_in && ready_out; on that edge data_in is written into the holding register and full is set.
REQ-021 A transfer at a byte boundary SHALL happen in the same edge as the unload: the old byte goes to the shift register and the new byte to the holding register, so no gap and no loss.
REQ-022 valid_in while ready_out is low SHALL be ignored; nothing is stored.
REQ-023 A data byte equal to COM SHALL be sent unchanged, with no escaping.
REQ-024 Latency from transfer to the first bit of that byte on data_out SHALL be 1 to 8 clk_32f cycles, at the next byte boundary.
REQ-025 Sustained throughput SHALL be one byte per 8 cycles with valid_in held high.

Reset
REQ-026 While reset is high, the following SHALL be forced at once, without waiting for a clock: shift register 8'h00 (data_out=0), bit counter 7, sync counter 0, full 0, holding register 8'h00, state SYNC, ready_out 0, active 0.
REQ-027 The first edge after reset release SHALL be a byte boundary loading COM.
REQ-028 Reset during a byte or with full set SHALL drop that byte; the preamble SHALL restart in full.

Structure
REQ-029 COM, SYNC_COUNT and the FSM state encoding SHALL sit in the shared constants package/include, shared with serial_paralelo.
REQ-030 One sub-module is natural: paralelo_serial_shift, an 8-bit load/shift register with bit counter and boundary flag; the FSM and holding register stay in the top module.

Verification
REQ-031 Release reset with valid_in=0 -> data_out repeats 10111100 from edge 1; active and ready_out rise after edge 25; COM continues as idle.
REQ-032 After active, transfer 8'hAA -> bits 10101010 on edges 33-40, then idle COM 10111100.
REQ-033 Hold valid_in with AA, BB, CC, DD, EE, FF -> ready_out low whenever full and not at a boundary; stream is contiguous with no COM between bytes; ready_out pulses at boundaries.
REQ-034 After FF, drop valid_in for 8 cycles and then send 8'h00 -> 11111111, 10111100, 00000000.
REQ-035 Assert reset at bit 3 of a byte with full=1 -> data_out, ready_out and active go to 0 at once; after release, 4 full COMs are sent before active, and the held byte is never sent.
REQ-036 Drive valid_in=1 with 8'h55 during SYNC -> no transfer; the first data byte after active is the one presented while ready_out is high.

Source files
------------

// File: rtl/paralelo_serial_pkg.sv
// paralelo_serial_pkg: link constants and FSM encoding shared by paralelo_serial and serial_paralelo
package paralelo_serial_pkg;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam int SYNC_LEN = 4;
  typedef enum logic {SYNC, ACTIVE} link_state_t;
endpackage

// File: rtl/paralelo_serial_shift.sv
// paralelo_serial_shift: 8-bit load/shift register, MSB first, with bit counter and byte-boundary flag
module paralelo_serial_shift (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] load_byte,
  output logic       data_out,
  output logic       boundary
);
  logic [7:0] sr;
  logic [2:0] cnt;
  // boundary is high when the coming edge wraps the counter 7->0 and loads a byte
  assign boundary = cnt == 3'd7;
  assign data_out = sr[7];
  always_ff @(posedge clk_32f or posedge reset)
    if (reset) begin
      sr  <= 8'h00;
      cnt <= 3'd7;
    end else begin
      cnt <= cnt + 3'd1;
      sr  <= boundary ? load_byte : {sr[6:0], 1'b0};
    end
endmodule

// File: rtl/paralelo_serial.sv
// paralelo_serial: byte-to-bit serializer with COM sync preamble, idle fill and a one-byte holding register
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter logic [7:0] COM        = COM_SYM,
  parameter int         SYNC_COUNT = SYNC_LEN
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active
);
  localparam int SW = $clog2(SYNC_COUNT + 1);
  link_state_t state;
  logic [SW-1:0] sync_cnt;
  logic [7:0] hold;
  logic full, boundary, xfer;
  logic [7:0] load_byte;
  assign active    = state == ACTIVE;
  assign ready_out = active && (!full || boundary);
  assign xfer      = valid_in && ready_out;
  assign load_byte = active && full ? hold : COM;
  paralelo_serial_shift u_shift (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .load_byte(load_byte),
    .data_out (data_out),
    .boundary (boundary)
  );
  // a transfer on a boundary edge refills the register the shifter is unloading
  always_ff @(posedge clk_32f or posedge reset)
    if (reset) begin
      state    <= SYNC;
      sync_cnt <= '0;
      full     <= 1'b0;
      hold     <= 8'h00;
    end else begin
      if (xfer) hold <= data_in;
      full <= xfer || (full && !boundary);
      if (state == SYNC && boundary) begin
        sync_cnt <= sync_cnt + 1'b1;
        if (sync_cnt == SW'(SYNC_COUNT - 1)) state <= ACTIVE;
      end
    end
endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial: randomized scoreboard bench comparing the serial stream against a byte-slot model
module tb_paralelo_serial;
  localparam logic [7:0] COM = 8'hBC;
  localparam int SYNC_COUNT = 4;
  logic clk_32f = 0, reset = 0, valid_in = 0;
  logic [7:0] data_in = 0;
  logic ready_out, data_out, active;
  paralelo_serial #(.COM(COM), .SYNC_COUNT(SYNC_COUNT)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .active   (active)
  );
  always #5 clk_32f = ~clk_32f;
  int tests = 0, fails = 0;
  logic [7:0] pend[$];
  logic [7:0] exp_bytes[$];
  int edges = 0, slots = 0, nbits = 0;
  logic [7:0] shreg = 0;
  bit bnd, acc;
  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: every 8th edge starts a byte slot; slots carry COM in preamble, then a pending byte or COM
  always @(posedge clk_32f) if (!reset) begin
    bnd = edges % 8 == 0;
    acc = valid_in && slots >= SYNC_COUNT && (pend.size() == 0 || bnd);
    if (bnd) begin
      exp_bytes.push_back(slots < SYNC_COUNT ? COM : (pend.size() != 0 ? pend.pop_front() : COM));
      slots++;
    end
    if (acc) pend.push_back(data_in);
    edges++;
  end
  always @(negedge clk_32f) if (!reset && edges > 0) begin
    check("active", {7'b0, active}, {7'b0, slots >= SYNC_COUNT});
    check("ready_out", {7'b0, ready_out}, {7'b0, slots >= SYNC_COUNT && (pend.size() == 0 || edges % 8 == 0)});
    shreg = {shreg[6:0], data_out};
    nbits++;
    if (nbits == 8) begin
      nbits = 0;
      if (exp_bytes.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL byte: got %h expected nothing queued", shreg);
      end else check("byte", shreg, exp_bytes.pop_front());
    end
  end
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk_32f); #1;
      valid_in = 0;
    end
  endtask
  task automatic send_seq(input logic [7:0] bytes[$]);
    int i = 0, guard = 0;
    while (i < bytes.size() && guard < 200) begin
      @(negedge clk_32f); #1;
      valid_in = 1;
      data_in = bytes[i];
      if (ready_out) i++;
      guard++;
    end
    if (i < bytes.size()) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got %0d bytes accepted expected %0d", i, bytes.size());
    end
    @(negedge clk_32f); #1;
    valid_in = 0;
  endtask
  task automatic rand_traffic(int n);
    repeat (n) begin
      @(negedge clk_32f); #1;
      valid_in = $urandom_range(99) < 60;
      data_in = $urandom_range(3) == 0 ? COM : 8'($urandom);
    end
    valid_in = 0;
  endtask
  task automatic do_reset(int hold_cycles);
    @(posedge clk_32f); #3;
    reset = 1;
    #1;
    check("rst_data_out", {7'b0, data_out}, 8'h00);
    check("rst_ready_out", {7'b0, ready_out}, 8'h00);
    check("rst_active", {7'b0, active}, 8'h00);
    pend.delete();
    exp_bytes.delete();
    edges = 0;
    slots = 0;
    nbits = 0;
    valid_in = 0;
    repeat (hold_cycles) @(negedge clk_32f);
    #1 reset = 0;
  endtask
  initial begin
    #1 reset = 1;
    #1;
    check("init_data_out", {7'b0, data_out}, 8'h00);
    check("init_ready_out", {7'b0, ready_out}, 8'h00);
    check("init_active", {7'b0, active}, 8'h00);
    @(negedge clk_32f); #1 reset = 0;
    idle(40);
    send_seq('{8'hAA});
    idle(20);
    send_seq('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF});
    idle(8);
    send_seq('{8'h00});
    idle(16);
    rand_traffic(300);
    idle(8);
    send_seq('{8'hAB, 8'h12});
    repeat (3) @(negedge clk_32f);
    do_reset(2);
    repeat (40) begin
      @(negedge clk_32f); #1;
      valid_in = 1;
      data_in = 8'h55;
    end
    idle(20);
    send_seq('{COM, 8'h3C});
    rand_traffic(200);
    idle(24);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
